// File: rtl/vending_machine_pkg.sv
// Shared types and constants for the multi-product vending machine.
package vending_machine_pkg;

    // Coin values in nickel units.
    localparam int NICKEL_V  = 1;
    localparam int DIME_V    = 2;
    localparam int QUARTER_V = 5;

    // One-hot FSM encoding: serve and change emit commands are single state bits.
    typedef enum logic [4:0] {
        ST_DEPOSIT     = 5'b00001,
        ST_SERVE_EMIT  = 5'b00010,
        ST_SERVE_WAIT  = 5'b00100,
        ST_CHANGE_EMIT = 5'b01000,
        ST_CHANGE_WAIT = 5'b10000
    } vm_state_e;

    localparam int ST_SERVE_EMIT_BIT  = 1;
    localparam int ST_CHANGE_EMIT_BIT = 3;

    // One-hot change coin: bit 0 nickel, bit 1 dime, bit 2 quarter.
    typedef enum logic [2:0] {
        COIN_NONE    = 3'b000,
        COIN_NICKEL  = 3'b001,
        COIN_DIME    = 3'b010,
        COIN_QUARTER = 3'b100
    } coin_sel_e;

    function automatic int coin_value(input coin_sel_e coin);
        case (coin)
            COIN_QUARTER: return QUARTER_V;
            COIN_DIME:    return DIME_V;
            COIN_NICKEL:  return NICKEL_V;
            default:      return 0;
        endcase
    endfunction

endpackage

// File: rtl/vm_change_sel.sv
// Greedy change denomination chooser: largest coin not exceeding the credit.
module vm_change_sel
    import vending_machine_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] i_credit,
    output coin_sel_e           o_coin,
    output logic [CREDIT_W-1:0] o_dec
);

    // Pick the largest denomination that fits; zero credit selects nothing.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        o_coin = COIN_NONE;
        if (i_credit >= CREDIT_W'(QUARTER_V)) begin
            o_coin = COIN_QUARTER;
        end else if (i_credit >= CREDIT_W'(DIME_V)) begin
            o_coin = COIN_DIME;
        end else if (i_credit != '0) begin
            o_coin = COIN_NICKEL;
        end
    end

    assign o_dec = CREDIT_W'(coin_value(o_coin));

endmodule

// File: rtl/vending_machine_mp.sv
// Multi-product vending controller: credit datapath, price compare bank and FSM.
module vending_machine_mp
    import vending_machine_pkg::*;
#(
    parameter int                             N_PRODUCTS  = 4,
    parameter int                             CREDIT_W    = 8,
    parameter logic [N_PRODUCTS*CREDIT_W-1:0] PRICES      = {8'd8, 8'd5, 8'd12, 8'd20},
    parameter bit                             AUTO_CHANGE = 1'b1,
    localparam int                            ID_W        = (N_PRODUCTS > 1) ? $clog2(N_PRODUCTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  client_nickel,
    input  logic                  client_dime,
    input  logic                  client_quarter,
    input  logic                  client_select,
    input  logic [ID_W-1:0]       client_sel_id,
    input  logic                  client_cancel,
    output logic [CREDIT_W-1:0]   client_credit_r,
    output logic [N_PRODUCTS-1:0] client_enough_r,
    output logic                  client_coin_reject_r,
    output logic                  client_sel_nack_r,
    input  logic                  serve_done,
    output logic                  serve_emit_r,
    output logic [ID_W-1:0]       serve_id_r,
    input  logic                  change_done,
    output logic                  change_emit_quarter_r,
    output logic                  change_emit_dime_r,
    output logic                  change_emit_nickel_r
);

    // Extra headroom so credit plus a full cycle of coins never wraps.
    localparam int                SUM_W      = CREDIT_W + 4;
    localparam logic [SUM_W-1:0] CREDIT_MAX = {4'b0000, {CREDIT_W{1'b1}}};

    // PRICES is packed with product 0 in the most significant slot.
    function automatic logic [CREDIT_W-1:0] price_of(input int idx);
        return PRICES[(N_PRODUCTS-1-idx)*CREDIT_W +: CREDIT_W];
    endfunction

    vm_state_e           r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [ID_W-1:0]     r_serve_id, w_serve_id_nxt;
    logic                r_coin_reject, w_coin_reject_nxt;
    logic                r_sel_nack, w_sel_nack_nxt;

    logic [SUM_W-1:0]    w_coin_sum;
    logic [SUM_W-1:0]    w_credit_sum;
    logic                w_coin_any;
    logic                w_coin_fit;
    logic [CREDIT_W-1:0] w_credit_acc;
    logic [CREDIT_W-1:0] w_price;
    logic                w_id_ok;
    logic                w_afford;
    coin_sel_e           w_coin;
    logic [CREDIT_W-1:0] w_change_dec;

    assign w_coin_any   = client_nickel | client_dime | client_quarter;
    assign w_coin_sum   = (client_nickel  ? SUM_W'(NICKEL_V)  : '0)
                        + (client_dime    ? SUM_W'(DIME_V)    : '0)
                        + (client_quarter ? SUM_W'(QUARTER_V) : '0);
    assign w_credit_sum = SUM_W'(r_credit) + w_coin_sum;
    assign w_coin_fit   = (w_credit_sum <= CREDIT_MAX);
    // Coins are all-or-nothing: an overflowing cycle leaves the credit untouched.
    assign w_credit_acc = w_coin_fit ? w_credit_sum[CREDIT_W-1:0] : r_credit;

    // Price mux for the requested product; out-of-range ids read as zero and are nacked.
    always_comb begin
        w_price = '0;
        for (int i = 0; i < N_PRODUCTS; i++) begin
            if (32'(client_sel_id) == 32'(i)) w_price = price_of(i);
        end
    end

    assign w_id_ok  = (32'(client_sel_id) < 32'(N_PRODUCTS));
    assign w_afford = (r_credit >= w_price);

    // Affordability bank from registered credit only.
    for (genvar g = 0; g < N_PRODUCTS; g++) begin : g_enough
        assign client_enough_r[g] = (r_credit >= price_of(g));
    end

    vm_change_sel #(
        .CREDIT_W (CREDIT_W)
    ) u_change_sel (
        .i_credit (r_credit),
        .o_coin   (w_coin),
        .o_dec    (w_change_dec)
    );

    // Next-state, next-credit and pulse decode for the vend/change sequence.
    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_serve_id_nxt    = r_serve_id;
        w_coin_reject_nxt = w_coin_any;
        w_sel_nack_nxt    = 1'b0;
        case (r_state)
            ST_DEPOSIT: begin
                w_coin_reject_nxt = w_coin_any && !w_coin_fit;
                w_credit_nxt      = w_credit_acc;
                if (client_cancel) begin
                    if (r_credit != '0) w_state_nxt = ST_CHANGE_EMIT;
                end else if (client_select) begin
                    if (w_id_ok && w_afford) begin
                        w_credit_nxt   = w_credit_acc - w_price;
                        w_serve_id_nxt = client_sel_id;
                        w_state_nxt    = ST_SERVE_EMIT;
                    end else begin
                        w_sel_nack_nxt = 1'b1;
                    end
                end
            end
            ST_SERVE_EMIT: begin
                w_state_nxt = ST_SERVE_WAIT;
            end
            ST_SERVE_WAIT: begin
                if (serve_done) begin
                    if (r_credit != '0 && AUTO_CHANGE) w_state_nxt = ST_CHANGE_EMIT;
                    else                               w_state_nxt = ST_DEPOSIT;
                end
            end
            ST_CHANGE_EMIT: begin
                w_credit_nxt = r_credit - w_change_dec;
                w_state_nxt  = ST_CHANGE_WAIT;
            end
            ST_CHANGE_WAIT: begin
                if (change_done) begin
                    w_state_nxt = (r_credit == '0) ? ST_DEPOSIT : ST_CHANGE_EMIT;
                end
            end
            default: begin
                w_state_nxt  = ST_DEPOSIT;
                w_credit_nxt = '0;
            end
        endcase
    end

    // State, credit and registered pulse flops; reset discards any credit in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state       <= ST_DEPOSIT;
            r_credit      <= '0;
            r_serve_id    <= '0;
            r_coin_reject <= 1'b0;
            r_sel_nack    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_serve_id    <= w_serve_id_nxt;
            r_coin_reject <= w_coin_reject_nxt;
            r_sel_nack    <= w_sel_nack_nxt;
        end
    end

    assign client_credit_r       = r_credit;
    assign client_coin_reject_r  = r_coin_reject;
    assign client_sel_nack_r     = r_sel_nack;
    assign serve_emit_r          = r_state[ST_SERVE_EMIT_BIT];
    assign serve_id_r            = r_serve_id;
    assign change_emit_quarter_r = r_state[ST_CHANGE_EMIT_BIT] & w_coin[2];
    assign change_emit_dime_r    = r_state[ST_CHANGE_EMIT_BIT] & w_coin[1];
    assign change_emit_nickel_r  = r_state[ST_CHANGE_EMIT_BIT] & w_coin[0];

endmodule

// File: tb/tb_vending_machine_mp.sv
// Scoreboard bench: DUT A uses default parameters, DUT B a 4-bit credit with credit retention.
module tb_vending_machine_mp;

    typedef struct packed {
        logic       nickel;
        logic       dime;
        logic       quarter;
        logic       select;
        logic [1:0] sel_id;
        logic       cancel;
        logic       serve_done;
        logic       change_done;
    } drv_t;

    typedef struct packed {
        logic       serve_emit;
        logic [1:0] serve_id;
        logic       cq;
        logic       cd;
        logic       cn;
        logic       reject;
        logic       nack;
        logic [7:0] credit;
        logic [3:0] enough;
    } obs_t;

    typedef enum logic [2:0] {
        EV_NONE, EV_SERVE, EV_QUARTER, EV_DIME, EV_NICKEL, EV_REJECT, EV_NACK
    } ev_kind_e;

    typedef struct packed {
        logic [1:0] dut;
        ev_kind_e   kind;
        logic [3:0] data;
        logic [7:0] credit;
    } ev_t;

    logic clk;
    logic rst_n;
    drv_t din [2];
    obs_t obs [2];
    ev_t  sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic       a_emit, a_cq, a_cd, a_cn, a_rej, a_nack;
    logic [1:0] a_id;
    logic [7:0] a_credit;
    logic [3:0] a_enough;
    logic       b_emit, b_cq, b_cd, b_cn, b_rej, b_nack;
    logic [1:0] b_id;
    logic [3:0] b_credit;
    logic [3:0] b_enough;

    vending_machine_mp #(
        .N_PRODUCTS (4),
        .CREDIT_W   (8),
        .PRICES     ({8'd8, 8'd5, 8'd12, 8'd20}),
        .AUTO_CHANGE(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .client_nickel(din[0].nickel), .client_dime(din[0].dime), .client_quarter(din[0].quarter),
        .client_select(din[0].select), .client_sel_id(din[0].sel_id), .client_cancel(din[0].cancel),
        .client_credit_r(a_credit), .client_enough_r(a_enough),
        .client_coin_reject_r(a_rej), .client_sel_nack_r(a_nack),
        .serve_done(din[0].serve_done), .serve_emit_r(a_emit), .serve_id_r(a_id),
        .change_done(din[0].change_done),
        .change_emit_quarter_r(a_cq), .change_emit_dime_r(a_cd), .change_emit_nickel_r(a_cn)
    );

    vending_machine_mp #(
        .N_PRODUCTS (4),
        .CREDIT_W   (4),
        .PRICES     ({4'd8, 4'd5, 4'd12, 4'd14}),
        .AUTO_CHANGE(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .client_nickel(din[1].nickel), .client_dime(din[1].dime), .client_quarter(din[1].quarter),
        .client_select(din[1].select), .client_sel_id(din[1].sel_id), .client_cancel(din[1].cancel),
        .client_credit_r(b_credit), .client_enough_r(b_enough),
        .client_coin_reject_r(b_rej), .client_sel_nack_r(b_nack),
        .serve_done(din[1].serve_done), .serve_emit_r(b_emit), .serve_id_r(b_id),
        .change_done(din[1].change_done),
        .change_emit_quarter_r(b_cq), .change_emit_dime_r(b_cd), .change_emit_nickel_r(b_cn)
    );

    assign obs[0] = {a_emit, a_id, a_cq, a_cd, a_cn, a_rej, a_nack, a_credit, a_enough};
    assign obs[1] = {b_emit, b_id, b_cq, b_cd, b_cn, b_rej, b_nack, 4'b0000, b_credit, b_enough};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input int k, input ev_kind_e kind, input int data, input int credit);
        ev_t e;
        e = '{dut: 2'(k), kind: kind, data: 4'(data), credit: 8'(credit)};
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input int k, input ev_kind_e kind, input int data, input int credit);
        ev_t got;
        ev_t exp;
        got = '{dut: 2'(k), kind: kind, data: 4'(data), credit: 8'(credit)};
        if (sb_q.size() == 0) begin
            check("sb_unexpected", 32'(got), 32'(0));
        end else begin
            exp = sb_q.pop_front();
            check("sb_event", 32'(got), 32'(exp));
        end
    endtask

    // Monitor: every output pulse of either DUT consumes one expected event.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (obs[k].serve_emit) sb_pop(k, EV_SERVE,   int'(obs[k].serve_id), int'(obs[k].credit));
                if (obs[k].cq)         sb_pop(k, EV_QUARTER, 0, int'(obs[k].credit));
                if (obs[k].cd)         sb_pop(k, EV_DIME,    0, int'(obs[k].credit));
                if (obs[k].cn)         sb_pop(k, EV_NICKEL,  0, int'(obs[k].credit));
                if (obs[k].reject)     sb_pop(k, EV_REJECT,  0, int'(obs[k].credit));
                if (obs[k].nack)       sb_pop(k, EV_NACK,    0, int'(obs[k].credit));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe of client inputs; returns one step after the sampling edge.
    task automatic drive(input int k, input logic n, input logic d, input logic q,
                         input logic sel, input int id, input logic cancel);
        step();
        din[k].nickel  = n;
        din[k].dime    = d;
        din[k].quarter = q;
        din[k].select  = sel;
        din[k].sel_id  = 2'(id);
        din[k].cancel  = cancel;
        step();
        din[k].nickel  = 1'b0;
        din[k].dime    = 1'b0;
        din[k].quarter = 1'b0;
        din[k].select  = 1'b0;
        din[k].cancel  = 1'b0;
    endtask

    task automatic wait_emit(input int k);
        int lat;
        bit found;
        lat   = 0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (obs[k].serve_emit) begin
                found = 1'b1;
                break;
            end
            lat++;
            step();
        end
        check("serve_emit_seen", 32'(found), 32'(1));
        check("serve_emit_latency", 32'(lat), 32'(0));
    endtask

    task automatic ack_serve(input int k);
        step();
        din[k].serve_done = 1'b1;
        step();
        din[k].serve_done = 1'b0;
    endtask

    task automatic hopper(input int k, input int n_coins);
        for (int c = 0; c < n_coins; c++) begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (obs[k].cq || obs[k].cd || obs[k].cn) begin
                    found = 1'b1;
                    break;
                end
                step();
            end
            check("change_pulse_seen", 32'(found), 32'(1));
            step();
            din[k].change_done = 1'b1;
            step();
            din[k].change_done = 1'b0;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        din[0] = '0;
        din[1] = '0;
        #1;
        check("a_reset_outputs", 32'(obs[0]), 32'(0));
        check("b_reset_outputs", 32'(obs[1]), 32'(0));
        #11;
        rst_n = 1'b1;

        // Exact payment: quarter+dime+nickel = 8 buys product 0, no change.
        drive(0, 1, 1, 1, 0, 0, 0);
        check("a_credit_8", 32'(a_credit), 32'(8));
        check("a_enough_8", 32'(a_enough), 32'(4'b0011));
        expect_ev(0, EV_SERVE, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        wait_emit(0);
        ack_serve(0);
        repeat (3) step();
        check("a_credit_after_exact", 32'(a_credit), 32'(0));

        // Two quarters, buy product 1, dime refused while serving, quarter change.
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        check("a_credit_10", 32'(a_credit), 32'(10));
        expect_ev(0, EV_SERVE, 1, 5);
        expect_ev(0, EV_REJECT, 0, 5);
        expect_ev(0, EV_QUARTER, 0, 5);
        drive(0, 0, 0, 0, 1, 1, 0);
        wait_emit(0);
        step();
        din[0].dime = 1'b1;
        step();
        din[0].dime       = 1'b0;
        din[0].serve_done = 1'b1;
        step();
        din[0].serve_done = 1'b0;
        hopper(0, 1);
        check("a_credit_after_change", 32'(a_credit), 32'(0));

        // Credit 3 cancelled: dime then nickel.
        drive(0, 1, 1, 0, 0, 0, 0);
        check("a_credit_3", 32'(a_credit), 32'(3));
        expect_ev(0, EV_DIME, 0, 3);
        expect_ev(0, EV_NICKEL, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        hopper(0, 2);
        check("a_credit_after_cancel", 32'(a_credit), 32'(0));

        // Credit 7: unaffordable product 3 nacked; cancel beats a valid select.
        drive(0, 0, 1, 1, 0, 0, 0);
        check("a_enough_7", 32'(a_enough), 32'(4'b0010));
        expect_ev(0, EV_NACK, 0, 7);
        drive(0, 0, 0, 0, 1, 3, 0);
        check("a_credit_after_nack", 32'(a_credit), 32'(7));
        expect_ev(0, EV_QUARTER, 0, 7);
        expect_ev(0, EV_DIME, 0, 2);
        drive(0, 0, 0, 0, 1, 1, 1);
        hopper(0, 2);
        check("a_credit_after_cancel_sel", 32'(a_credit), 32'(0));

        // DUT B: saturation at 15; 14 + dime refused, then refund 14.
        drive(1, 0, 1, 1, 0, 0, 0);
        drive(1, 0, 1, 1, 0, 0, 0);
        check("b_credit_14", 32'(b_credit), 32'(14));
        check("b_enough_14", 32'(b_enough), 32'(4'b1111));
        expect_ev(1, EV_REJECT, 0, 14);
        drive(1, 0, 1, 0, 0, 0, 0);
        check("b_credit_sat", 32'(b_credit), 32'(14));
        expect_ev(1, EV_QUARTER, 0, 14);
        expect_ev(1, EV_QUARTER, 0, 9);
        expect_ev(1, EV_DIME, 0, 4);
        expect_ev(1, EV_DIME, 0, 2);
        drive(1, 0, 0, 0, 0, 0, 1);
        hopper(1, 4);
        check("b_credit_after_refund", 32'(b_credit), 32'(0));

        // DUT B retains credit: 13 - 8 = 5 left in DEPOSIT.
        drive(1, 1, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0, 0);
        check("b_credit_13", 32'(b_credit), 32'(13));
        expect_ev(1, EV_SERVE, 0, 5);
        drive(1, 0, 0, 0, 1, 0, 0);
        wait_emit(1);
        ack_serve(1);
        repeat (3) step();
        check("b_credit_retained", 32'(b_credit), 32'(5));
        check("b_enough_retained", 32'(b_enough), 32'(4'b0010));

        // Asynchronous reset during CHANGE_WAIT discards the remaining credit.
        drive(1, 0, 1, 0, 0, 0, 0);
        expect_ev(1, EV_QUARTER, 0, 7);
        drive(1, 0, 0, 0, 0, 0, 1);
        step();
        check("b_credit_in_change_wait", 32'(b_credit), 32'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check("b_async_reset_outputs", 32'(obs[1]), 32'(0));
        check("a_async_reset_outputs", 32'(obs[0]), 32'(0));
        step();
        #2;
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        din[1].change_done = 1'b1;
        step();
        din[1].change_done = 1'b0;
        drive(1, 1, 0, 0, 0, 0, 0);
        check("b_credit_after_reset", 32'(b_credit), 32'(1));
        expect_ev(1, EV_NICKEL, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 1);
        hopper(1, 1);
        check("b_credit_final", 32'(b_credit), 32'(0));

        repeat (5) step();
        check("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/vending_machine_mp.md
# vending_machine_mp

Multi-product vending-machine controller; next generation of the single-product dime-change machine. Accepts nickel/dime/quarter deposits into a nickel-unit credit register and serves one of `N_PRODUCTS` items, each with its own parametrised price. Returns change greedily in quarters, dimes and nickels, supports client cancel/refund, and optionally retains credit for repeat purchases. Sits between the client coin/keypad front-end, the product serve mechanism and the coin-change hopper.

## Interface
- `N_PRODUCTS`, 4: number of selectable products (1..16).
- `CREDIT_W`, 8: credit register width, in nickel units.
- `PRICES`, {8,5,12,20}: per-product price in nickels, `N_PRODUCTS` x `CREDIT_W` packed; every entry must be nonzero.
- `AUTO_CHANGE`, 1: 1 = refund remaining credit after every vend; 0 = keep credit for further vends.

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `client_nickel` / `client_dime` / `client_quarter` in 1 each: coin strobes, one cycle per coin; several may assert in one cycle.
- `client_select` in 1: purchase request strobe.
- `client_sel_id` in $clog2(N_PRODUCTS): product index; valid with `client_select`.
- `client_cancel` in 1: refund request strobe.
- `client_credit_r` out CREDIT_W: current credit.
- `client_enough_r` out N_PRODUCTS: bit i set when credit >= PRICES[i].
- `client_coin_reject_r` out 1: one-cycle pulse; a coin was refused.
- `client_sel_nack_r` out 1: one-cycle pulse; a selection was refused.
- `serve_done` in 1: serve mechanism finished.
- `serve_emit_r` out 1: one-cycle vend command.
- `serve_id_r` out $clog2(N_PRODUCTS): product to vend; valid with `serve_emit_r`.
- `change_done` in 1: hopper finished ejecting the last coin.
- `change_emit_quarter_r` / `change_emit_dime_r` / `change_emit_nickel_r` out 1 each: one-cycle coin-eject commands, mutually exclusive.

## Operation
- Coin values: nickel 1, dime 2, quarter 5. The sum of strobed coins in a cycle is added in DEPOSIT only.
- Saturation: if credit + sum of coins exceeds 2^CREDIT_W-1, all coins of that cycle are refused. Coins in any non-DEPOSIT state are always refused. A refusal raises `client_coin_reject_r`.
- States: DEPOSIT, SERVE_EMIT, SERVE_WAIT, CHANGE_EMIT, CHANGE_WAIT.
- DEPOSIT:
  - `client_cancel` with credit>0 goes to CHANGE_EMIT. Cancel with credit=0 does nothing.
  - `client_select` with credit_r >= PRICES[id] and id < N_PRODUCTS: credit becomes credit_r - price + accepted coins; latch id; go to SERVE_EMIT.
  - Any other select: credit is unchanged and `client_sel_nack_r` pulses.
  - Cancel beats select in the same cycle; the select is dropped with no nack.
  - Selection affordability uses registered credit only; coins arriving in the same cycle do not count.
- SERVE_EMIT: always goes to SERVE_WAIT after one cycle.
- SERVE_WAIT: on `serve_done`:
  - credit=0 goes to DEPOSIT.
  - otherwise, AUTO_CHANGE=1 goes to CHANGE_EMIT.
  - otherwise, AUTO_CHANGE=0 goes to DEPOSIT.
- CHANGE_EMIT: choose a coin greedily and subtract its value from credit in the same cycle.
  - credit >= 5: quarter.
  - credit >= 2: dime.
  - otherwise: nickel.
- CHANGE_WAIT: on `change_done`, credit=0 goes to DEPOSIT, otherwise back to CHANGE_EMIT.
- `serve_done`/`change_done` outside their wait states are ignored. `client_select`/`client_cancel` outside DEPOSIT are ignored with no nack.
- Reset values: state DEPOSIT; credit 0; all outputs 0.

## Timing
- Coin at cycle t: `client_credit_r` and `client_enough_r` update at t+1. A reject pulse, if any, appears at t+1.
- Accepted select at t: `serve_emit_r`=1 and `serve_id_r` valid at t+1 only; SERVE_WAIT from t+2.
  - `serve_done` sampled at t+2 or later.
  - Nack pulse at t+1.
- Change emit pulses are decoded from the state register: one cycle per coin. The earliest next pulse is 2 cycles after a `change_done` that is sampled as soon as possible.
- Credit drops by the coin value in the cycle after its emit pulse.
- All outputs are registered or decoded directly from flops, with no combinational path from inputs.
- Reset asserted mid-vend or mid-change: immediate return to reset values; credit is lost by design.

## Structure
- `vending_machine_pkg` holds:
  - the FSM state enum, one-hot-friendly encoding with emit bits decodable directly;
  - coin value constants NICKEL_V/DIME_V/QUARTER_V;
  - the coin select enum.
- Sub-module `vm_change_sel`: combinational greedy denomination chooser. Takes credit in; produces a one-hot coin and a decrement value.
- The top holds the FSM, credit datapath, price mux and compare bank.

## Test plan
- Default params: quarter+dime+nickel (credit 8) then select id 0 → `serve_emit_r` with id 0. After `serve_done`, credit 0 and DEPOSIT; no change pulses.
- Two quarters (credit 10), select id 1 (price 5), AUTO_CHANGE=1 → serve, then a single quarter pulse; credit 0 after `change_done`.
- Credit 3, cancel → dime pulse, `change_done`, nickel pulse, `change_done` → DEPOSIT with credit 0.
- Credit 7, select id 3 (price 20) → `client_sel_nack_r` at t+1; credit stays 7. Cancel and select in the same cycle → refund only, no nack.
- CREDIT_W=4: credit 14 plus a dime → reject pulse; credit stays 14. Dime inserted during SERVE_WAIT → rejected.
- AUTO_CHANGE=0: credit 13, vend id 0 → credit 5 retained in DEPOSIT; `client_enough_r`=4'b0010. Reset deasserted-asserted mid CHANGE_WAIT → all outputs 0 asynchronously.
